// File: rtl/piso_pkg.sv
// Shared types and defaults for the PISO serial transmitter.
package piso_pkg;

  typedef enum logic {IDLE, SHIFT} piso_state_t;

  localparam int PISO_DEFAULT_WIDTH = 8;

endpackage

// File: rtl/piso_bit_counter.sv
// Bit-position counter for the PISO transmitter; flags the final bit of a word.
module piso_bit_counter #(
  parameter int N = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic last
);

  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(N - 1);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  // Clear wins over enable so a word accepted in its predecessor's final cycle restarts at 0.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign last = (count_q == LAST_CNT);

endmodule

// File: rtl/piso_serializer_tx.sv
// Parallel-in/serial-out transmitter with gapless back-to-back words.
// Optional even-parity trailer bit enabled by defining PISO_PARITY_EN.
module piso_serializer_tx
  import piso_pkg::*;
#(
  parameter int WIDTH     = PISO_DEFAULT_WIDTH,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] pIn,
  input  logic             load,
  output logic             ready,
  output logic             sOut,
  output logic             sValid,
  output logic             done
);

`ifdef PISO_PARITY_EN
  localparam int N = WIDTH + 1;
`else
  localparam int N = WIDTH;
`endif

  piso_state_t      state_q;
  piso_state_t      state_d;
  logic [WIDTH-1:0] shreg_q;
  logic [WIDTH-1:0] shreg_d;
  logic [WIDTH-1:0] shifted;
  logic             in_shift;
  logic             last;
  logic             load_acc;
  logic             data_bit;

  assign in_shift = (state_q == SHIFT);
  assign load_acc = load & ready;
  assign shifted  = MSB_FIRST ? {shreg_q[WIDTH-2:0], 1'b0} : {1'b0, shreg_q[WIDTH-1:1]};
  assign data_bit = MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0];

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    if (in_shift) begin
      shreg_d = shifted;
    end
    if (load_acc) begin
      state_d = SHIFT;
      shreg_d = pIn;
    end else if (in_shift && last) begin
      state_d = IDLE;
    end
  end

`ifdef PISO_PARITY_EN
  logic parity_q;
  logic parity_d;

  assign parity_d = load_acc ? ^pIn : parity_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      shreg_q  <= '0;
`ifdef PISO_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      shreg_q  <= shreg_d;
`ifdef PISO_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  piso_bit_counter #(
    .N(N)
  ) u_bit_counter (
    .clk  (clk),
    .rst  (rst),
    .clr  (load_acc),
    .en   (in_shift),
    .last (last)
  );

  // The parity trailer occupies the final slot, so it is selected by the same last flag as done.
`ifdef PISO_PARITY_EN
  assign sOut = in_shift & (last ? parity_q : data_bit);
`else
  assign sOut = in_shift & data_bit;
`endif

  assign sValid = in_shift;
  assign done   = in_shift & last;
  assign ready  = ~in_shift | last;

endmodule
